training_scheduler: RTL and testbench
=====================================

// Module: training_scheduler
// PURPOSE
//  Top-level sequencer for on-chip XOR training. Steps through the 4 XOR samples each epoch and
//  runs each sample as forward pass, backward pass, then weight commit. It drives the forward
//  block (enable_fp/fp_valid level handshake) and the backprop block (enable_bp/bp_valid).
//  Accumulates per-epoch |y-target| error and stops on epoch limit, convergence, abort or timeout.
// PARAMETERS
//  dataWidth   16   sample/target/y width, signed 8.8 fixed point
//  EPOCH_W     16   epoch counter width
//  TIMEOUT     255  max cycles waiting for fp_valid or bp_valid
//  TO_W        8    watchdog counter width; must satisfy 2**TO_W > TIMEOUT
// PORTS
//  clk            in   1            clock
//  rst            in   1            async active-high reset
//  start          in   1            pulse; begins training when IDLE, ignored otherwise
//  abort          in   1            level; forces return to IDLE
//  num_epochs     in   EPOCH_W      epoch limit; sampled on start; 0 => done immediately
//  err_threshold  in   dataWidth+2  convergence bound on epoch error sum (unsigned)
//  x1,x2,target   out  dataWidth    current sample; registered, signed
//  enable_fp      out  1            forward enable (level)
//  fp_valid       in   1            forward complete
//  y              in   dataWidth    forward output; valid while fp_valid=1
//  enable_bp      out  1            backprop enable (level)
//  bp_valid       in   1            backprop complete
//  update_en      out  1            1-cycle weight-commit pulse
//  busy           out  1            high whenever state != IDLE/DONE
//  done           out  1            held high in DONE
//  converged      out  1            done caused by error threshold
//  timeout_err    out  1            sticky; handshake timed out
//  epoch_cnt      out  EPOCH_W      completed epochs
//  sample_idx     out  2            current sample 0..3
//  epoch_err      out  dataWidth+2  error sum of last completed epoch
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE.
//  - Sample table: idx0 (0,0)->0; idx1 (0,1)->1; idx2 (1,0)->1; idx3 (1,1)->0.
//    1.0 = 16'sh0100.
//  - IDLE: on start, clear epoch_cnt, accumulator, sample_idx, converged and timeout_err.
//    If num_epochs==0 go to DONE, else go to LOAD.
//  - LOAD (1 cyc): drive x1/x2/target from sample_idx. Next FWD.
//  - FWD: enable_fp=1. On fp_valid: capture |y-target| into accumulator, saturating at all-ones.
//    Then enable_fp=0 and go to FWD_REL.
//  - FWD_REL: enable_fp held 0 for >=1 cycle, until fp_valid=0. Next BWD.
//  - BWD: enable_bp=1 until bp_valid. Then enable_bp=0 and go to UPDATE.
//  - UPDATE (1 cyc): update_en=1.
//    If sample_idx<3: increment sample_idx and go to LOAD.
//    If sample_idx==3: go to EPOCH_END.
//  - EPOCH_END (1 cyc): epoch_err<=accumulator, accumulator<=0, epoch_cnt++, sample_idx<=0.
//    If accumulator<=err_threshold: converged=1, go to DONE.
//    Else if epoch_cnt+1==num_epochs: go to DONE.
//    Else go to LOAD.
//  - DONE: done=1 until the next start (restart as from IDLE).
//  - Watchdog: counts cycles in FWD or BWD and clears on entry to either. At count==TIMEOUT:
//    timeout_err=1, drop all enables, go to DONE.
//  - abort: has priority over all transitions. Next cycle: enables=0, state IDLE, done=0.
//    Counters and epoch_err are kept.
//  - Fixed per-sample overhead: LOAD+FWD_REL+UPDATE = 3 cycles plus handshake latencies.
//    EPOCH_END adds 1 cycle per epoch.
//  - enable_fp and enable_bp are never high together. update_en is never high with either.
//  - start while busy: ignored. start and abort in the same cycle: abort wins.
// STRUCTURE
//  - Shared package: state encoding (IDLE, LOAD, FWD, FWD_REL, BWD, UPDATE, EPOCH_END, DONE),
//    Q8.8 constants ONE=16'sh0100 and ZERO, and the 4-entry XOR sample/target table.
//  - One sub-module: xor_sample_rom (combinational idx -> x1,x2,target).
//  - FSM, watchdog and error accumulator stay in this module.
// TESTING
//  1. num_epochs=2, threshold=0, model fp_valid after 3 cyc with y=0, bp_valid after 4 cyc
//     -> 8 update_en pulses, idx order 0,1,2,3,0,1,2,3.
//     -> epoch_err=0x200 (2.0), epoch_cnt=2, done=1, converged=0.
//  2. threshold=0x080, model y==target every sample -> converged=1 after epoch 1, epoch_cnt=1.
//  3. fp_valid never returns, TIMEOUT=255 -> timeout_err=1 on cycle 255 of FWD, enable_fp=0, done=1.
//  4. abort asserted mid-BWD -> next cycle enable_bp=0, busy=0, done=0, state IDLE.
//     -> later start restarts at idx0 with epoch_cnt=0.
//  5. num_epochs=0 -> DONE one cycle after start, no enable_fp pulse.
//     start while busy -> ignored, counts unchanged.
//  6. rst asserted mid-FWD -> all outputs 0 asynchronously.
//     Checker asserts enables are mutually exclusive throughout.

Source files
------------

// File: rtl/training_scheduler_pkg.sv
// Shared definitions for the XOR training scheduler: FSM state encoding,
// Q8.8 constants and the four-entry XOR sample/target table.
package training_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FWD,
        ST_FWD_REL,
        ST_BWD,
        ST_UPDATE,
        ST_EPOCH_END,
        ST_DONE
    } state_t;

    localparam logic signed [15:0] ONE  = 16'sh0100;
    localparam logic signed [15:0] ZERO = 16'sh0000;

    typedef struct packed {
        logic signed [15:0] x1;
        logic signed [15:0] x2;
        logic signed [15:0] target;
    } sample_t;

    function automatic sample_t xor_sample(input logic [1:0] idx);
        sample_t s;
        case (idx)
            2'd0:    s = '{x1: ZERO, x2: ZERO, target: ZERO};
            2'd1:    s = '{x1: ZERO, x2: ONE,  target: ONE};
            2'd2:    s = '{x1: ONE,  x2: ZERO, target: ONE};
            default: s = '{x1: ONE,  x2: ONE,  target: ZERO};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/xor_sample_rom.sv
// Combinational lookup of the XOR training sample and target for a sample index.
module xor_sample_rom
    import training_scheduler_pkg::*;
#(
    parameter int dataWidth = 16
) (
    input  logic        [1:0]           idx,
    output logic signed [dataWidth-1:0] x1,
    output logic signed [dataWidth-1:0] x2,
    output logic signed [dataWidth-1:0] target
);

    sample_t s;

    always_comb begin
        s      = xor_sample(idx);
        x1     = dataWidth'(s.x1);
        x2     = dataWidth'(s.x2);
        target = dataWidth'(s.target);
    end

endmodule

// File: rtl/training_scheduler.sv
// Epoch/sample sequencer for on-chip XOR training: drives forward and backprop
// handshakes, commits weights, accumulates |y-target| and stops on limit/convergence/abort/timeout.
module training_scheduler
    import training_scheduler_pkg::*;
#(
    parameter int dataWidth = 16,
    parameter int EPOCH_W   = 16,
    parameter int TIMEOUT   = 255,
    parameter int TO_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic        [EPOCH_W-1:0]   num_epochs,
    input  logic        [dataWidth+1:0] err_threshold,
    output logic signed [dataWidth-1:0] x1,
    output logic signed [dataWidth-1:0] x2,
    output logic signed [dataWidth-1:0] target,
    output logic                        enable_fp,
    input  logic                        fp_valid,
    input  logic signed [dataWidth-1:0] y,
    output logic                        enable_bp,
    input  logic                        bp_valid,
    output logic                        update_en,
    output logic                        busy,
    output logic                        done,
    output logic                        converged,
    output logic                        timeout_err,
    output logic        [EPOCH_W-1:0]   epoch_cnt,
    output logic        [1:0]           sample_idx,
    output logic        [dataWidth+1:0] epoch_err
);

    localparam int ACC_W = dataWidth + 2;

    state_t state, next_state;

    logic        [TO_W-1:0]      wd_cnt;
    logic                        wd_expired;
    logic        [ACC_W-1:0]     acc;
    logic        [ACC_W-1:0]     acc_sat;
    logic        [ACC_W:0]       acc_sum;
    logic signed [dataWidth:0]   diff;
    logic        [dataWidth:0]   abs_err;
    logic        [EPOCH_W-1:0]   num_epochs_q;
    logic        [EPOCH_W-1:0]   epoch_cnt_inc;
    logic signed [dataWidth-1:0] rom_x1, rom_x2, rom_target;

    logic do_clear, do_load, do_capture, do_inc_idx;
    logic do_epoch_end, do_converge, do_timeout;

    xor_sample_rom #(.dataWidth(dataWidth)) u_rom (
        .idx    (sample_idx),
        .x1     (rom_x1),
        .x2     (rom_x2),
        .target (rom_target)
    );

    // Absolute error is one bit wider than the operands; the accumulator saturates at all-ones.
    always_comb begin
        diff    = (dataWidth+1)'(y) - (dataWidth+1)'(target);
        abs_err = diff[dataWidth] ? $unsigned(-diff) : $unsigned(diff);
        acc_sum = {1'b0, acc} + {2'b00, abs_err};
        acc_sat = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    end

    assign wd_expired    = (wd_cnt == TO_W'(TIMEOUT));
    assign epoch_cnt_inc = epoch_cnt + EPOCH_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        next_state   = state;
        do_clear     = 1'b0;
        do_load      = 1'b0;
        do_capture   = 1'b0;
        do_inc_idx   = 1'b0;
        do_epoch_end = 1'b0;
        do_converge  = 1'b0;
        do_timeout   = 1'b0;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        do_clear   = 1'b1;
                        next_state = (num_epochs == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    do_load    = 1'b1;
                    next_state = ST_FWD;
                end
                ST_FWD: begin
                    if (fp_valid) begin
                        do_capture = 1'b1;
                        next_state = ST_FWD_REL;
                    end else if (wd_expired) begin
                        do_timeout = 1'b1;
                        next_state = ST_DONE;
                    end
                end
                ST_FWD_REL: begin
                    if (!fp_valid) next_state = ST_BWD;
                end
                ST_BWD: begin
                    if (bp_valid) begin
                        next_state = ST_UPDATE;
                    end else if (wd_expired) begin
                        do_timeout = 1'b1;
                        next_state = ST_DONE;
                    end
                end
                ST_UPDATE: begin
                    if (sample_idx == 2'd3) begin
                        next_state = ST_EPOCH_END;
                    end else begin
                        do_inc_idx = 1'b1;
                        next_state = ST_LOAD;
                    end
                end
                ST_EPOCH_END: begin
                    do_epoch_end = 1'b1;
                    if (acc <= err_threshold) begin
                        do_converge = 1'b1;
                        next_state  = ST_DONE;
                    end else if (epoch_cnt_inc == num_epochs_q) begin
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_LOAD;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    assign enable_fp = (state == ST_FWD);
    assign enable_bp = (state == ST_BWD);
    assign update_en = (state == ST_UPDATE);
    assign done      = (state == ST_DONE);
    assign busy      = !((state == ST_IDLE) || (state == ST_DONE));

    // Watchdog is zero outside FWD/BWD, so it restarts from zero on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if ((state == ST_FWD || state == ST_BWD) && next_state == state) begin
            wd_cnt <= wd_cnt + TO_W'(1);
        end else begin
            wd_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1           <= '0;
            x2           <= '0;
            target       <= '0;
            acc          <= '0;
            epoch_err    <= '0;
            epoch_cnt    <= '0;
            sample_idx   <= '0;
            num_epochs_q <= '0;
            converged    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here updates from pre-edge values.
            if (do_clear) begin
                epoch_cnt    <= '0;
                acc          <= '0;
                sample_idx   <= '0;
                converged    <= 1'b0;
                timeout_err  <= 1'b0;
                num_epochs_q <= num_epochs;
            end
            if (do_load) begin
                x1     <= rom_x1;
                x2     <= rom_x2;
                target <= rom_target;
            end
            if (do_capture) acc        <= acc_sat;
            if (do_inc_idx) sample_idx <= sample_idx + 2'd1;
            if (do_epoch_end) begin
                epoch_err  <= acc;
                acc        <= '0;
                epoch_cnt  <= epoch_cnt_inc;
                sample_idx <= '0;
            end
            if (do_converge) converged   <= 1'b1;
            if (do_timeout)  timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_training_scheduler.sv
// Scoreboard bench for training_scheduler: stimulus queues expected commits and
// end-of-run results; a monitor pops and compares on update_en pulses and done rising.
module tb_training_scheduler;

    localparam int TIMEOUT = 255;

    logic               clk = 1'b0;
    logic               rst, start, abort;
    logic        [15:0] num_epochs;
    logic        [17:0] err_threshold;
    logic signed [15:0] x1, x2, target, y;
    logic               enable_fp, fp_valid, enable_bp, bp_valid, update_en;
    logic               busy, done, converged, timeout_err;
    logic        [15:0] epoch_cnt;
    logic        [1:0]  sample_idx;
    logic        [17:0] epoch_err;

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] x1, x2, target;
    } samp_exp_t;

    typedef struct {
        logic [15:0] epochs;
        logic [17:0] err;
        logic        conv;
        logic        tmo;
    } done_exp_t;

    samp_exp_t samp_q[$];
    done_exp_t done_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int fp_lat  = 3;
    int bp_lat  = 4;
    bit y_match  = 1'b0;
    bit fp_never = 1'b0;

    always #5 clk = ~clk;

    training_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .num_epochs    (num_epochs),
        .err_threshold (err_threshold),
        .x1            (x1),
        .x2            (x2),
        .target        (target),
        .enable_fp     (enable_fp),
        .fp_valid      (fp_valid),
        .y             (y),
        .enable_bp     (enable_bp),
        .bp_valid      (bp_valid),
        .update_en     (update_en),
        .busy          (busy),
        .done          (done),
        .converged     (converged),
        .timeout_err   (timeout_err),
        .epoch_cnt     (epoch_cnt),
        .sample_idx    (sample_idx),
        .epoch_err     (epoch_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_samp(input logic [1:0] i, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] t);
        samp_exp_t e;
        e.idx = i; e.x1 = a; e.x2 = b; e.target = t;
        samp_q.push_back(e);
    endtask

    task automatic push_epoch();
        push_samp(2'd0, 16'h0000, 16'h0000, 16'h0000);
        push_samp(2'd1, 16'h0000, 16'h0100, 16'h0100);
        push_samp(2'd2, 16'h0100, 16'h0000, 16'h0100);
        push_samp(2'd3, 16'h0100, 16'h0100, 16'h0000);
    endtask

    task automatic push_done(input logic [15:0] ep, input logic [17:0] err, input logic cv,
                             input logic to);
        done_exp_t e;
        e.epochs = ep; e.err = err; e.conv = cv; e.tmo = to;
        done_q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, done, 1'b1);
    endtask

    // Forward/backprop responder: valid after a fixed latency, dropped once the enable falls.
    initial begin
        int fp_cnt, bp_cnt;
        fp_cnt = 0; bp_cnt = 0;
        fp_valid = 1'b0; bp_valid = 1'b0; y = '0;
        forever begin
            @(posedge clk);
            #1;
            if (enable_fp && !fp_never) begin
                fp_cnt++;
                if (fp_cnt >= fp_lat) begin
                    fp_valid = 1'b1;
                    y = y_match ? target : 16'sh0000;
                end
            end else begin
                fp_cnt = 0;
                fp_valid = 1'b0;
            end
            if (enable_bp) begin
                bp_cnt++;
                if (bp_cnt >= bp_lat) bp_valid = 1'b1;
            end else begin
                bp_cnt = 0;
                bp_valid = 1'b0;
            end
        end
    end

    // Monitor: enable exclusivity every cycle, sample commits and end-of-run results.
    initial begin
        logic prev_done;
        samp_exp_t s;
        done_exp_t d;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("enables_exclusive",
                      {30'd0, enable_fp & enable_bp, update_en & (enable_fp | enable_bp)}, 32'd0);
                if (update_en) begin
                    if (samp_q.size() == 0) begin
                        check("unexpected_update", update_en, 1'b0);
                    end else begin
                        s = samp_q.pop_front();
                        check("upd_idx", sample_idx, s.idx);
                        check("upd_x1", x1, s.x1);
                        check("upd_x2", x2, s.x2);
                        check("upd_target", target, s.target);
                    end
                end
                if (done && !prev_done) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_done", done, 1'b0);
                    end else begin
                        d = done_q.pop_front();
                        check("done_epoch_cnt", epoch_cnt, d.epochs);
                        check("done_epoch_err", epoch_err, d.err);
                        check("done_converged", converged, d.conv);
                        check("done_timeout_err", timeout_err, d.tmo);
                        check("done_enables", {enable_fp, enable_bp}, 2'b00);
                    end
                end
            end
            prev_done = done;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        int fp_cycles;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        num_epochs = '0; err_threshold = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_enable_fp", enable_fp, 1'b0);
        check("rst_enable_bp", enable_bp, 1'b0);
        check("rst_update_en", update_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_flags", {converged, timeout_err}, 2'b00);
        check("rst_counts", {epoch_cnt, sample_idx}, 18'd0);
        check("rst_sample", {x1, x2, target}, 48'd0);
        check("rst_epoch_err", epoch_err, 18'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two full epochs, y=0: error 2.0 per epoch, no convergence at threshold 0
        num_epochs = 16'd2; err_threshold = 18'h0; y_match = 1'b0;
        push_epoch(); push_epoch();
        push_done(16'd2, 18'h200, 1'b0, 1'b0);
        pulse_start();
        check("t1_busy", busy, 1'b1);
        wait_done("t1", 300);
        @(negedge clk);
        check("t1_samples_left", samp_q.size(), 0);
        check("t1_results_left", done_q.size(), 0);
        check("t1_done_held", done, 1'b1);

        // Perfect outputs converge after the first epoch
        num_epochs = 16'd5; err_threshold = 18'h080; y_match = 1'b1;
        push_epoch();
        push_done(16'd1, 18'h0, 1'b1, 1'b0);
        pulse_start();
        wait_done("t2", 300);
        @(negedge clk);
        check("t2_samples_left", samp_q.size(), 0);

        // Forward never completes: watchdog fires on FWD cycle index TIMEOUT
        fp_never = 1'b1; num_epochs = 16'd3; err_threshold = 18'h0; y_match = 1'b0;
        push_done(16'd0, 18'h0, 1'b0, 1'b1);
        pulse_start();
        fp_cycles = 0; n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            if (enable_fp) fp_cycles++;
            n++;
        end
        check("t3_done", done, 1'b1);
        check("t3_fp_cycles", fp_cycles, TIMEOUT + 1);
        check("t3_enable_fp", enable_fp, 1'b0);
        check("t3_timeout_err", timeout_err, 1'b1);
        fp_never = 1'b0;
        @(negedge clk);

        // Abort mid-BWD in the second epoch: back to IDLE, counters kept
        num_epochs = 16'd2;
        push_epoch();
        pulse_start();
        n = 0;
        while (epoch_cnt != 16'd1 && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (!enable_bp && n < 100) begin @(negedge clk); n++; end
        check("t4_in_bwd", enable_bp, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_enable_bp", enable_bp, 1'b0);
        check("t4_busy", busy, 1'b0);
        check("t4_done", done, 1'b0);
        check("t4_epoch_cnt_kept", epoch_cnt, 16'd1);
        check("t4_epoch_err_kept", epoch_err, 18'h200);
        check("t4_samples_left", samp_q.size(), 0);
        // start together with abort: abort wins, nothing is cleared
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("t4_sa_busy", busy, 1'b0);
        check("t4_sa_epoch_cnt", epoch_cnt, 16'd1);
        @(negedge clk);
        check("t4_sa_idle", {busy, done}, 2'b00);
        // Restart from sample 0 with a cleared epoch count
        num_epochs = 16'd1;
        push_epoch();
        push_done(16'd1, 18'h200, 1'b0, 1'b0);
        pulse_start();
        check("t4_restart_cnt", epoch_cnt, 16'd0);
        check("t4_restart_idx", sample_idx, 2'd0);
        wait_done("t4", 200);
        @(negedge clk);

        // num_epochs = 0 finishes one cycle after start without a forward pass
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        num_epochs = 16'd0;
        push_done(16'd0, 18'h200, 1'b0, 1'b0);
        pulse_start();
        check("t5_done", done, 1'b1);
        check("t5_busy", busy, 1'b0);
        fp_cycles = 0;
        repeat (4) begin
            @(negedge clk);
            if (enable_fp) fp_cycles++;
        end
        check("t5_no_fp", fp_cycles, 0);

        // start while busy is ignored, including its num_epochs
        num_epochs = 16'd1;
        push_epoch();
        push_done(16'd1, 18'h200, 1'b0, 1'b0);
        pulse_start();
        n = 0;
        while (!(sample_idx == 2'd1 && enable_bp) && n < 100) begin @(negedge clk); n++; end
        num_epochs = 16'd7;
        pulse_start();
        check("t5_busy_idx", sample_idx, 2'd1);
        check("t5_busy_cnt", epoch_cnt, 16'd0);
        wait_done("t5", 200);
        @(negedge clk);
        check("t5_samples_left", samp_q.size(), 0);

        // Asynchronous reset in the middle of a forward pass
        num_epochs = 16'd2;
        push_epoch();
        push_samp(2'd0, 16'h0000, 16'h0000, 16'h0000);
        push_samp(2'd1, 16'h0000, 16'h0100, 16'h0100);
        pulse_start();
        n = 0;
        while (!(epoch_cnt == 16'd1 && sample_idx == 2'd2 && enable_fp) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t6_in_fwd", {enable_fp, x1}, {1'b1, 16'h0100});
        #2 rst = 1'b1;
        #1;
        check("t6_enables", {enable_fp, enable_bp, update_en}, 3'b000);
        check("t6_status", {busy, done, converged, timeout_err}, 4'b0000);
        check("t6_counts", {epoch_cnt, sample_idx}, 18'd0);
        check("t6_sample", {x1, x2, target}, 48'd0);
        check("t6_epoch_err", epoch_err, 18'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_samples_left", samp_q.size(), 0);
        check("t6_results_left", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
